// File: rtl/balanced_adder_checker.sv
// Scoreboard for the balanced tree adder. It computes the golden sum of the
// packed input lanes and delays it by the adder latency. It then compares the
// delayed sum against the adder output and keeps pass/error statistics plus a
// capture of the first failing compare.

// Zero-extends one input lane to the full sum width.
module balanced_adder_checker_lane #(
  parameter int DW = 8,
  parameter int SW = 32
) (
  input  logic [DW-1:0] lane,
  output logic [SW-1:0] ext
);
  assign ext = SW'(lane);
endmodule

module balanced_adder_checker #(
  parameter int DW          = 8,
  parameter int N           = 4,
  parameter int LAT         = 4,
  parameter int CW          = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [(2**N)*DW-1:0]    inp,
  input  logic [DW*N-1:0]         dut_sum,
  output logic                    busy,
  output logic                    done_ok,
  output logic                    err_flag,
  output logic [CW-1:0]           pass_cnt,
  output logic [CW-1:0]           err_cnt,
  output logic [DW*N-1:0]         first_exp,
  output logic [DW*N-1:0]         first_got,
  output logic [1:0]              state
);
  localparam int NL = 2**N;
  localparam int SW = DW*N;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} st_t;

  st_t st_q, st_d;

  logic [NL-1:0][SW-1:0]  lane_ext;
  logic [SW-1:0]          exp_sum;
  logic [LAT-1:0]         vld_pipe;
  logic [LAT-1:0][SW-1:0] exp_pipe;
  logic                   tap_vld;
  logic [SW-1:0]          tap_exp;
  logic                   cmp_en;
  logic                   match;
  logic                   rem;

  genvar k;
  generate
    for (k = 0; k < NL; k++) begin : g_lane
      balanced_adder_checker_lane #(.DW(DW), .SW(SW)) u_lane (
        .lane (inp[k*DW +: DW]),
        .ext  (lane_ext[k])
      );
    end
  endgenerate

  // Golden sum: wraps modulo 2**SW by construction of the accumulator width.
  always_comb begin
    exp_sum = '0;
    for (int i = 0; i < NL; i++) exp_sum = exp_sum + lane_ext[i];
  end

  assign tap_vld = vld_pipe[LAT-1];
  assign tap_exp = exp_pipe[LAT-1];
  assign match   = (tap_exp == dut_sum);
  assign cmp_en  = tap_vld && (st_q == RUN);

  // Tags still in flight after this cycle's shift; the outgoing tap is excluded
  // so RUN can drop to IDLE on the same edge the last compare retires.
  always_comb begin
    rem = 1'b0;
    for (int i = 0; i < LAT-1; i++) rem = rem | vld_pipe[i];
  end

  // Delay line of {valid, expected}; it keeps shifting in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      exp_pipe <= '0;
    end else begin
      vld_pipe[0] <= en;
      exp_pipe[0] <= exp_sum;
      for (int i = 1; i < LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        exp_pipe[i] <= exp_pipe[i-1];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  // Next-state logic; HALT is only left through reset.
  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE: if (en) st_d = RUN;
      RUN: begin
        if (cmp_en && !match && (STOP_ON_ERR != 0)) st_d = HALT;
        else if (!en && !rem)                       st_d = IDLE;
      end
      HALT:    st_d = HALT;
      default: st_d = IDLE;
    endcase
  end

  // Statistics and first-failure capture, updated only by live compares.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt  <= '0;
      err_cnt   <= '0;
      err_flag  <= 1'b0;
      first_exp <= '0;
      first_got <= '0;
    end else if (cmp_en) begin
      if (match) begin
        if (pass_cnt != {CW{1'b1}}) pass_cnt <= pass_cnt + 1'b1;
      end else begin
        if (err_cnt != {CW{1'b1}}) err_cnt <= err_cnt + 1'b1;
        if (!err_flag) begin
          err_flag  <= 1'b1;
          first_exp <= tap_exp;
          first_got <= dut_sum;
        end
      end
    end
  end

  assign busy    = |vld_pipe;
  assign done_ok = (st_q == IDLE) && (pass_cnt != '0) && (err_cnt == '0);
  assign state   = st_q;

endmodule

// File: doc/balanced_adder_checker.md
Name: balanced_adder_checker

Overview:
- Self-checking consumer for the balanced tree adder's output, sitting at the opposite end of the stimulus path.
- Samples the same packed input vector presented to the adder and computes the golden sum.
- Delays the golden sum by the adder's pipeline latency, compares it against the adder result every cycle, and keeps pass/error statistics plus first-failure capture.

Parameters:
DW, 8, width of one input lane
N, 4, tree depth; 2**N lanes per input vector
LAT, 4, adder pipeline latency in cycles from inp sampled to outp valid (>=1)
CW, 16, width of pass/error counters
STOP_ON_ERR, 0, 1 = halt checking on the first mismatch; 0 = keep checking

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  qualifies inp this cycle as a valid sample to check
inp  in  (2**N)*DW  packed lanes fed to the adder; lane k = inp[k*DW +: DW]
dut_sum  in  DW*N  adder output
busy  out  1  high while any valid sample is in the delay line
done_ok  out  1  high in IDLE when pass_cnt>0 and err_cnt==0
err_flag  out  1  sticky, set on first mismatch
pass_cnt  out  CW  matched comparisons, saturating
err_cnt  out  CW  mismatched comparisons, saturating
first_exp  out  DW*N  expected value at first mismatch
first_got  out  DW*N  dut_sum at first mismatch
state  out  2  0=IDLE, 1=RUN, 2=HALT

Behaviour:
Reset:
- Asserting rst at any time, including mid-run, clears every output, every delay-line entry and all valid tags, and forces IDLE.
- No reset pulse is required after power-on initial state beyond this.
Golden sum:
- exp = sum of all 2**N lanes, each lane zero-extended, computed modulo 2**(DW*N).
- exp is computed combinationally from inp in the same cycle it is sampled.
Delay line:
- The delay line is LAT stages of {valid, exp}.
- Each cycle, stage 0 loads {en, exp} and every stage shifts by one.
- The entry leaving stage LAT-1 is compared with dut_sum that same cycle.
- A sample taken at cycle t is therefore checked at cycle t+LAT.
Compare:
- Compare happens only when the outgoing tag is 1 and state is RUN.
- Match: pass_cnt+1.
- Mismatch: err_cnt+1.
- On the first mismatch only: err_flag<=1, first_exp<=exp, first_got<=dut_sum. Later mismatches never overwrite these captures.
Counters:
- Both counters saturate at 2**CW-1 and do not wrap.
FSM:
- IDLE -> RUN when en=1.
- RUN -> IDLE when no valid tag remains in the pipe and en=0. Tags are drained, not discarded.
- RUN -> HALT on a mismatch when STOP_ON_ERR=1.
- In HALT, the delay line keeps shifting but no further compares or counter updates occur. HALT is left only by rst.
- With STOP_ON_ERR=0, RUN continues through mismatches.
busy:
- busy = OR of all delay-line valid tags.
Gaps:
- en=0 in the middle of a run inserts a bubble, and the matching dut_sum cycle is not checked.
- A burst restarting while earlier tags are still draining stays in RUN; no state change.
Same-cycle events:
- A compare and a new en on the same cycle are independent; both take effect.
- A mismatch on the same cycle as saturation still sets err_flag.
Latency of outputs:
- Counters and flags update on the clock edge following the compare cycle.
- done_ok and busy are registered-state derived, with no combinational path from dut_sum.

Test Plan:
- Lanes all 1 (N=4, DW=8), en=1 for 10 cycles, dut_sum = 16 delayed 4 cycles -> pass_cnt=10, err_cnt=0; then IDLE with done_ok=1 four cycles after en falls.
- Lanes all 0xFF, model correct -> exp=4080 (0x0FF0); 8 samples -> pass_cnt=8. Checks lane zero-extension.
- Counting stimulus starting at inp=32; dut_sum correct except sample 5 forced to 0, STOP_ON_ERR=0 -> err_cnt=1, first_exp=37, first_got=0, err_flag=1, remaining samples pass.
- Same injected error with STOP_ON_ERR=1 -> state=HALT one cycle after the mismatch; pass_cnt frozen at 5; busy drains to 0; state stays HALT until rst.
- en pattern 1,1,0,1,0,0,1 with dut_sum driven to garbage on the bubble cycles -> only 4 compares, pass_cnt=4, err_cnt=0.
- rst pulse while 3 valid tags are in flight -> all outputs 0, state=IDLE, busy=0 immediately (asynchronous), no compare on the following cycles.
